motoro_gate_guard: RTL and testbench

MOTORO_GATE_GUARD -- requirements
Module: motoro_gate_guard

---
 rtl/motoro_gate_guard.sv | 150 +++++++++++++++
 tb/tb_motoro_gate_guard.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motoro_gate_guard.sv
// rtl/motoro_gate_guard.sv - per-phase half-bridge gate guard with dead time and shoot-through fault latch
// Every phase has its own OFF/HP_ON/LN_ON/DEAD machine. A request conflict overrides all phases at once.
module motoro_gate_guard #(
  parameter int PHASES = 3,
  parameter int DT_W   = 8,
  parameter int FC_W   = 8
) (
  input  logic              clk50mhzI,
  input  logic              resetI,
  input  logic              enI,
  input  logic [PHASES-1:0] hpReqI,
  input  logic [PHASES-1:0] lnReqI,
  input  logic [DT_W-1:0]   deadTimeI,
  input  logic              faultClrI,
  output logic [PHASES-1:0] hpO,
  output logic [PHASES-1:0] lnO,
  output logic              faultO,
  output logic [3:0]        faultCodeO,
  output logic [FC_W-1:0]   faultCntO,
  output logic              tp01o
);

  typedef enum logic [1:0] {OFF, HP_ON, LN_ON, DEAD} phase_state_t;

  localparam logic [DT_W-1:0] DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};
  localparam logic [DT_W-1:0] DT_ZERO = '0;
  localparam logic [FC_W-1:0] FC_ONE = {{(FC_W-1){1'b0}}, 1'b1};
  localparam logic [FC_W-1:0] FC_MAX = '1;

  phase_state_t      state_q [PHASES];
  logic [DT_W-1:0]   cnt_q   [PHASES];

  logic [PHASES-1:0] hp_eff;
  logic [PHASES-1:0] ln_eff;
  logic [PHASES-1:0] conflict;
  logic [PHASES-1:0] dead_next;
  logic              any_conflict;
  logic [3:0]        conflict_code;

  // Conflicts are judged on raw requests so a held conflict also blocks fault clearing.
  assign conflict     = hpReqI & lnReqI & {PHASES{enI}};
  assign any_conflict = |conflict;
  assign hp_eff       = hpReqI & {PHASES{enI & ~faultO}};
  assign ln_eff       = lnReqI & {PHASES{enI & ~faultO}};

  always_comb begin
    conflict_code = 4'd0;
    for (int i = PHASES - 1; i >= 0; i--) begin
      if (conflict[i]) begin
        conflict_code = 4'(i + 1);
      end
    end
  end

  // Phases that will sit in DEAD after the coming edge, used for the registered test point.
  always_comb begin
    dead_next = '0;
    for (int i = 0; i < PHASES; i++) begin
      case (state_q[i])
        HP_ON:   dead_next[i] = ~hp_eff[i];
        LN_ON:   dead_next[i] = ~ln_eff[i];
        DEAD:    dead_next[i] = (cnt_q[i] != DT_ZERO);
        default: dead_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk50mhzI or posedge resetI) begin
    if (resetI) begin
      for (int i = 0; i < PHASES; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
      end
      hpO        <= '0;
      lnO        <= '0;
      faultO     <= 1'b0;
      faultCodeO <= 4'd0;
      faultCntO  <= '0;
      tp01o      <= 1'b0;
    end else if (!faultO && any_conflict) begin
      // Fault entry drops every gate immediately; dead time is deliberately skipped.
      for (int i = 0; i < PHASES; i++) begin
        state_q[i] <= OFF;
        cnt_q[i]   <= '0;
      end
      hpO        <= '0;
      lnO        <= '0;
      tp01o      <= 1'b0;
      faultO     <= 1'b1;
      faultCodeO <= conflict_code;
      if (faultCntO != FC_MAX) begin
        faultCntO <= faultCntO + FC_ONE;
      end
    end else begin
      if (faultO && faultClrI && !any_conflict) begin
        faultO     <= 1'b0;
        faultCodeO <= 4'd0;
      end
      tp01o <= |dead_next;
      for (int i = 0; i < PHASES; i++) begin
        hpO[i] <= 1'b0;
        lnO[i] <= 1'b0;
        case (state_q[i])
          OFF: begin
            if (hp_eff[i]) begin
              state_q[i] <= HP_ON;
              hpO[i]     <= 1'b1;
            end else if (ln_eff[i]) begin
              state_q[i] <= LN_ON;
              lnO[i]     <= 1'b1;
            end
          end
          HP_ON: begin
            if (hp_eff[i]) begin
              hpO[i] <= 1'b1;
            end else begin
              state_q[i] <= DEAD;
              cnt_q[i]   <= deadTimeI;
            end
          end
          LN_ON: begin
            if (ln_eff[i]) begin
              lnO[i] <= 1'b1;
            end else begin
              state_q[i] <= DEAD;
              cnt_q[i]   <= deadTimeI;
            end
          end
          DEAD: begin
            if (cnt_q[i] != DT_ZERO) begin
              cnt_q[i] <= cnt_q[i] - DT_ONE;
            end else if (hp_eff[i]) begin
              state_q[i] <= HP_ON;
              hpO[i]     <= 1'b1;
            end else if (ln_eff[i]) begin
              state_q[i] <= LN_ON;
              lnO[i]     <= 1'b1;
            end else begin
              state_q[i] <= OFF;
            end
          end
          default: begin
            state_q[i] <= OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motoro_gate_guard.sv
// tb/tb_motoro_gate_guard.sv - directed and mixed-request bench for motoro_gate_guard
// Two instances (3 phases / 8-bit count, 6 phases / 2-bit count) share stimulus and are checked against a bench model.
module tb_motoro_gate_guard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] hp_req = '0;
  logic [7:0] ln_req = '0;
  logic [7:0] dt = '0;

  logic [2:0] hp3, ln3;
  logic       f3, tp3;
  logic [3:0] code3;
  logic [7:0] cnt3;
  logic [5:0] hp6, ln6;
  logic       f6, tp6;
  logic [3:0] code6;
  logic [1:0] cnt6;

  int tests = 0;
  int fails = 0;

  always #10 clk = ~clk;

  motoro_gate_guard u_dut3 (
    .clk50mhzI(clk), .resetI(rst), .enI(en),
    .hpReqI(hp_req[2:0]), .lnReqI(ln_req[2:0]), .deadTimeI(dt), .faultClrI(clr),
    .hpO(hp3), .lnO(ln3), .faultO(f3), .faultCodeO(code3), .faultCntO(cnt3), .tp01o(tp3)
  );

  motoro_gate_guard #(.PHASES(6), .DT_W(8), .FC_W(2)) u_dut6 (
    .clk50mhzI(clk), .resetI(rst), .enI(en),
    .hpReqI(hp_req[5:0]), .lnReqI(ln_req[5:0]), .deadTimeI(dt), .faultClrI(clr),
    .hpO(hp6), .lnO(ln6), .faultO(f6), .faultCodeO(code6), .faultCntO(cnt6), .tp01o(tp6)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: per phase, which side conducts (0 none, 1 high, 2 low) and how many dead cycles remain.
  int m_drive [2][8];
  int m_dead  [2][8];
  int m_fault [2];
  int m_code  [2];
  int m_cnt   [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_drive[k][i] = 0;
        m_dead[k][i]  = 0;
      end
      m_fault[k] = 0;
      m_code[k]  = 0;
      m_cnt[k]   = 0;
    end
  endtask

  task automatic model_step(input int k);
    int n;
    int mx;
    int low;
    bit conf;
    bit hpe;
    bit lne;
    n = (k == 0) ? 3 : 6;
    mx = (k == 0) ? 255 : 3;
    low = 0;
    conf = 0;
    for (int i = 0; i < n; i++) begin
      if (en && hp_req[i] && ln_req[i] && !conf) begin
        conf = 1;
        low = i + 1;
      end
    end
    if (m_fault[k] == 0 && conf) begin
      m_fault[k] = 1;
      m_code[k] = low;
      if (m_cnt[k] < mx) m_cnt[k]++;
      for (int i = 0; i < 8; i++) begin
        m_drive[k][i] = 0;
        m_dead[k][i] = 0;
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      hpe = en && hp_req[i] && (m_fault[k] == 0);
      lne = en && ln_req[i] && (m_fault[k] == 0);
      if (m_dead[k][i] > 0) begin
        if (m_dead[k][i] == 1) begin
          m_dead[k][i] = 0;
          m_drive[k][i] = hpe ? 1 : (lne ? 2 : 0);
        end else begin
          m_dead[k][i]--;
        end
      end else if ((m_drive[k][i] == 1 && !hpe) || (m_drive[k][i] == 2 && !lne)) begin
        m_drive[k][i] = 0;
        m_dead[k][i] = int'(dt) + 1;
      end else if (m_drive[k][i] == 0) begin
        m_drive[k][i] = hpe ? 1 : (lne ? 2 : 0);
      end
    end
    if (m_fault[k] != 0 && clr && !conf) begin
      m_fault[k] = 0;
      m_code[k] = 0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic compare(input int k);
    logic [31:0] e_hp, e_ln, e_tp, a_hp, a_ln, a_tp, a_f, a_code, a_cnt;
    int n;
    n = (k == 0) ? 3 : 6;
    e_hp = 0;
    e_ln = 0;
    e_tp = 0;
    for (int i = 0; i < n; i++) begin
      if (m_drive[k][i] == 1) e_hp[i] = 1'b1;
      if (m_drive[k][i] == 2) e_ln[i] = 1'b1;
      if (m_dead[k][i] > 0) e_tp = 1;
    end
    if (k == 0) begin
      a_hp = {29'd0, hp3}; a_ln = {29'd0, ln3}; a_tp = {31'd0, tp3};
      a_f = {31'd0, f3}; a_code = {28'd0, code3}; a_cnt = {24'd0, cnt3};
    end else begin
      a_hp = {26'd0, hp6}; a_ln = {26'd0, ln6}; a_tp = {31'd0, tp6};
      a_f = {31'd0, f6}; a_code = {28'd0, code6}; a_cnt = {30'd0, cnt6};
    end
    check($sformatf("m%0d_hp", k), a_hp, e_hp);
    check($sformatf("m%0d_ln", k), a_ln, e_ln);
    check($sformatf("m%0d_tp", k), a_tp, e_tp);
    check($sformatf("m%0d_fault", k), a_f, 32'(m_fault[k]));
    check($sformatf("m%0d_code", k), a_code, 32'(m_code[k]));
    check($sformatf("m%0d_cnt", k), a_cnt, 32'(m_cnt[k]));
    check($sformatf("m%0d_overlap", k), a_hp & a_ln, 32'd0);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      compare(0);
      compare(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_hp", {29'd0, hp3}, 0);
    check("rst_fault", {31'd0, f3}, 0);
    check("rst_cnt", {24'd0, cnt3}, 0);
    check("rst_tp", {31'd0, tp3}, 0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    dt = 8'd4;

    hp_req = 8'h01;
    tick(1);
    check("hp_latency", {31'd0, hp3[0]}, 1);
    tick(9);
    hp_req = 8'h00;
    ln_req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("dead4_tp", {31'd0, tp3}, 1);
      check("dead4_gates", {30'd0, hp3[0], ln3[0]}, 0);
    end
    tick(1);
    check("ln_after_dead4", {31'd0, ln3[0]}, 1);

    dt = 8'd0;
    ln_req = 8'h00;
    hp_req = 8'h01;
    tick(1);
    check("dead0_gates", {30'd0, hp3[0], ln3[0]}, 0);
    check("dead0_tp", {31'd0, tp3}, 1);
    tick(1);
    check("hp_after_dead0", {31'd0, hp3[0]}, 1);

    hp_req = 8'h06;
    ln_req = 8'h06;
    tick(1);
    hp_req = 8'h00;
    ln_req = 8'h00;
    check("fault_set", {31'd0, f3}, 1);
    check("fault_code", {28'd0, code3}, 2);
    check("fault_cnt", {24'd0, cnt3}, 1);
    check("fault_gates", {26'd0, hp3, ln3}, 0);
    tick(1);
    hp_req = 8'h01;
    ln_req = 8'h01;
    tick(1);
    hp_req = 8'h00;
    ln_req = 8'h00;
    check("second_conflict_cnt", {24'd0, cnt3}, 1);
    check("second_conflict_code", {28'd0, code3}, 2);

    clr = 1'b1;
    hp_req = 8'h01;
    ln_req = 8'h01;
    tick(1);
    check("clr_vs_conflict", {31'd0, f3}, 1);
    hp_req = 8'h00;
    ln_req = 8'h00;
    tick(1);
    check("clr_fault", {31'd0, f3}, 0);
    check("clr_cnt_kept", {24'd0, cnt3}, 1);
    clr = 1'b0;

    hp_req = 8'h01;
    tick(1);
    check("req_after_clear", {31'd0, hp3[0]}, 1);

    hp_req = 8'h00;
    ln_req = 8'h01;
    dt = 8'd3;
    tick(1);
    check("dt_latch_tp", {31'd0, tp3}, 1);
    dt = 8'd50;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("dt_latch_hold", {31'd0, tp3}, 1);
    end
    tick(1);
    check("dt_latch_done", {31'd0, ln3[0]}, 1);

    dt = 8'd2;
    en = 1'b0;
    tick(3);
    check("en_fall_dead", {31'd0, tp3}, 1);
    tick(1);
    check("en_fall_off", {30'd0, ln3[0], tp3}, 0);
    check("en_fall_nofault", {31'd0, f3}, 0);
    en = 1'b1;
    ln_req = 8'h00;

    for (int k = 0; k < 5; k++) begin
      hp_req = 8'(1 << (k % 3));
      ln_req = 8'(1 << (k % 3));
      tick(1);
      check("sat_fault", {31'd0, f6}, 1);
      check("sat_code", {28'd0, code6}, 32'((k % 3) + 1));
      hp_req = 8'h00;
      ln_req = 8'h00;
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      check("sat_clear", {31'd0, f6}, 0);
    end
    check("cnt6_saturated", {30'd0, cnt6}, 3);
    check("cnt3_counted", {24'd0, cnt3}, 6);

    repeat (40) begin
      hp_req = 8'($urandom);
      ln_req = 8'($urandom) & ~hp_req;
      if ($urandom_range(0, 7) == 0) ln_req = ln_req | hp_req;
      clr = ($urandom_range(0, 3) == 0);
      en = ($urandom_range(0, 9) != 0);
      dt = 8'($urandom_range(0, 5));
      tick(int'($urandom_range(1, 8)));
    end

    hp_req = 8'h00;
    ln_req = 8'h00;
    en = 1'b1;
    clr = 1'b1;
    tick(8);
    clr = 1'b0;
    dt = 8'd200;
    hp_req = 8'h01;
    tick(2);
    hp_req = 8'h00;
    tick(10);
    #3 rst = 1'b1;
    #1;
    check("async_rst_tp", {31'd0, tp3}, 0);
    check("async_rst_gates", {26'd0, hp3, ln3}, 0);
    check("async_rst_cnt", {24'd0, cnt3}, 0);
    check("async_rst_cnt6", {30'd0, cnt6}, 0);
    @(negedge clk);
    rst = 1'b0;
    hp_req = 8'h01;
    tick(1);
    check("post_rst_hp", {31'd0, hp3[0]}, 1);
    check("post_rst_tp", {31'd0, tp3}, 0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
